mem_lsu: RTL and testbench

- Load/store unit sitting directly upstream of the data memory (dm) in the MEM stage.
- Accepts one load/store request at a time from the pipeline and issues word-only accesses to dm.
- Sub-word stores are performed as read-modify-write, because dm selects the word by Address[31:2] and always writes starting at byte lane 0.
- Loads read the full word, then shift and sign/zero-extend locally; the pipeline is stalled via req_ready/resp_valid.

---
 rtl/mem_lsu.sv | 202 ++++++++++++++++++++
 tb/tb_mem_lsu.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit in front of a word-only data memory.
// Sub-word stores are read-modify-write; loads are shifted and extended here.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_*                 pipeline request (valid/ready, we, funct3, addr, wdata)
//   resp_*                pipeline response (valid/ready, rdata, err)
//   MemRead, MemWrite,
//   DMType, Address,
//   Write_data            word-only access to dm
//   Read_data             dm read data, valid the cycle after MemRead
//   MemReady              dm status, not used for sequencing
// Optional: define LSU_STATS_EN to add stat_loads/stat_stores/stat_errs.
module mem_lsu #(
   parameter int unsigned MEM_WORDS = 8192,
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [2:0]  DMType,
   output logic [31:0] Address,
   output logic [31:0] Write_data,
   input  logic [31:0] Read_data,
   input  logic        MemReady
`ifdef LSU_STATS_EN
   ,
   output logic [31:0] stat_loads,
   output logic [31:0] stat_stores,
   output logic [31:0] stat_errs
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      CAP,
      WR,
      RESP
   } state_t;

   state_t state;
   state_t state_n;

   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [29:0] widx_q;
   logic [31:0] wr_q;

   logic        accept;
   logic [31:0] rel;
   logic [31:0] widx_n;
   logic        bad_f3;
   logic        misal;
   logic        oor;
   logic        req_err;

   logic [4:0]  sh;
   logic [31:0] lane;
   logic [31:0] ld_val;
   logic [31:0] mask;
   logic [31:0] merged;

   logic        unused_memready;
   assign unused_memready = MemReady;

   assign accept = req_valid & req_ready;
   assign rel    = req_addr - ADDR_BASE;
   assign widx_n = rel >> 2;
   assign oor    = (req_addr < ADDR_BASE) |
                   (widx_n >= MEM_WORDS);

   always_comb begin
      bad_f3 = 1'b0;
      misal  = 1'b0;
      case (req_funct3)
         3'b000, 3'b100: misal = 1'b0;
         3'b001, 3'b101: misal = req_addr[0];
         3'b010:         misal = |req_addr[1:0];
         default:        bad_f3 = 1'b1;
      endcase
      // unsigned variants have no store form
      if (req_we && req_funct3[2])
         bad_f3 = 1'b1;
   end

   assign req_err = bad_f3 | misal | oor;

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_err)
                  state_n = RESP;
               else if (req_we && req_funct3 == 3'b010)
                  state_n = WR;
               else
                  state_n = RD;
            end
         end
         RD:   state_n = CAP;
         CAP:  state_n = we_q ? WR : RESP;
         WR:   state_n = RESP;
         RESP: if (resp_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // byte lane selection shared by load extract and store merge
   assign sh   = {off_q, 3'b000};
   assign lane = Read_data >> sh;

   always_comb begin
      case (f3_q)
         3'b000:  ld_val = {{24{lane[7]}}, lane[7:0]};
         3'b001:  ld_val = {{16{lane[15]}}, lane[15:0]};
         3'b100:  ld_val = {24'h0, lane[7:0]};
         3'b101:  ld_val = {16'h0, lane[15:0]};
         default: ld_val = lane;
      endcase
   end

   assign mask   = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
   assign merged = (Read_data & ~mask) | ((wr_q << sh) & mask);

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q       <= 1'b0;
         f3_q       <= 3'b000;
         off_q      <= 2'b00;
         widx_q     <= '0;
         wr_q       <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         if (accept) begin
            we_q       <= req_we;
            f3_q       <= req_funct3;
            off_q      <= req_addr[1:0];
            widx_q     <= widx_n[29:0];
            wr_q       <= req_wdata;
            resp_rdata <= '0;
            resp_err   <= req_err;
         end
         if (state == CAP) begin
            if (we_q)
               wr_q <= merged;
            else
               resp_rdata <= ld_val;
         end
      end
   end

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign MemRead    = (state == RD);
   assign MemWrite   = (state == WR);
   assign DMType     = 3'b010;
   assign Address    = (MemRead | MemWrite) ? {widx_q, 2'b00} : 32'h0;
   assign Write_data = MemWrite ? wr_q : 32'h0;

`ifdef LSU_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_loads  <= '0;
         stat_stores <= '0;
         stat_errs   <= '0;
      end else if (resp_valid && resp_ready) begin
         if (resp_err) begin
            if (stat_errs != 32'hFFFF_FFFF)
               stat_errs <= stat_errs + 32'd1;
         end else if (we_q) begin
            if (stat_stores != 32'hFFFF_FFFF)
               stat_stores <= stat_stores + 32'd1;
         end else begin
            if (stat_loads != 32'hFFFF_FFFF)
               stat_loads <= stat_loads + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: randomized bench for mem_lsu with a dm model and
// a byte-level reference memory.
module tb_mem_lsu;

   localparam int unsigned MW = 8192;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        MemRead;
   logic        MemWrite;
   logic [2:0]  DMType;
   logic [31:0] Address;
   logic [31:0] Write_data;
   logic [31:0] Read_data;
   logic        MemReady;
`ifdef LSU_STATS_EN
   logic [31:0] stat_loads;
   logic [31:0] stat_stores;
   logic [31:0] stat_errs;
`endif

   mem_lsu #(.MEM_WORDS(MW), .ADDR_BASE(32'h0)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .DMType     (DMType),
      .Address    (Address),
      .Write_data (Write_data),
      .Read_data  (Read_data),
      .MemReady   (MemReady)
`ifdef LSU_STATS_EN
      ,
      .stat_loads  (stat_loads),
      .stat_stores (stat_stores),
      .stat_errs   (stat_errs)
`endif
   );

   always #5 clk = ~clk;

   // dm model: registered read, negedge write, side port for preload
   logic [31:0] dm_mem [MW];
   logic        pl_en = 1'b0;
   logic [31:0] pl_idx;
   logic [31:0] pl_dat;

   assign MemReady = 1'b1;

   always @(posedge clk)
      if (MemRead)
         Read_data <= dm_mem[Address[14:2]];

   always @(negedge clk) begin
      if (MemWrite)
         dm_mem[Address[14:2]] <= Write_data;
      else if (pl_en)
         dm_mem[pl_idx[12:0]] <= pl_dat;
   end

   // bus monitor
   int          mon_rd = 0;
   int          mon_wr = 0;
   logic [31:0] mon_ra, mon_wa, mon_wd;

   always @(negedge clk) begin
      if (MemRead) begin
         mon_rd++;
         mon_ra = Address;
      end
      if (MemWrite) begin
         mon_wr++;
         mon_wa = Address;
         mon_wd = Write_data;
      end
   end

   int n_vec = 0;
   int n_err = 0;
   int m_loads = 0;
   int m_stores = 0;
   int m_errs = 0;
   logic [31:0] ref_mem [MW];

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic preload(input int unsigned idx, input logic [31:0] d);
      ref_mem[idx] = d;
      pl_idx = idx;
      pl_dat = d;
      pl_en  = 1'b1;
      @(negedge clk);
      #1 pl_en = 1'b0;
   endtask

   // reference: byte-level view of the access rules
   task automatic model(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic err, output logic [31:0] rd,
                        output logic [31:0] wo, output int lat,
                        output int nr, output int nw);
      int unsigned idx;
      int unsigned off;
      int          sz;
      bit          legal;
      logic [31:0] w, m;
      idx   = addr / 4;
      off   = addr % 4;
      legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      if (we && f3 >= 4) legal = 0;
      sz  = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
      err = !legal || (addr % sz) != 0 || idx >= MW;
      rd  = 0;
      wo  = 0;
      nr  = 0;
      nw  = 0;
      if (err) begin
         lat = 1;
      end else if (!we) begin
         lat = 3;
         nr  = 1;
         w   = ref_mem[idx];
         m   = (sz == 1) ? 32'hFF : (sz == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
         rd  = (w >> (8 * off)) & m;
         if (f3 < 4 && sz < 4 && rd[8*sz-1])
            rd = rd | ~m;
      end else begin
         lat = (sz == 4) ? 2 : 4;
         nr  = (sz == 4) ? 0 : 1;
         nw  = 1;
         w   = ref_mem[idx];
         for (int k = 0; k < sz; k++)
            w[8*(off+k) +: 8] = wd[8*k +: 8];
         ref_mem[idx] = w;
         wo = w;
      end
   endtask

   task automatic xact(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int hold, output logic [31:0] rd,
                       output logic er);
      logic        e_err;
      logic [31:0] e_rd, e_wd;
      int          e_lat, e_nr, e_nw, lat, r0, w0;
      model(we, f3, addr, wd, e_err, e_rd, e_wd, e_lat, e_nr, e_nw);
      @(negedge clk);
      check("idle_ready", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      resp_ready = (hold == 0);
      r0 = mon_rd;
      w0 = mon_wr;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      check("busy_ready", 32'(req_ready), 32'd0);
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(e_lat));
      check("rdata", resp_rdata, e_rd);
      check("err", 32'(resp_err), 32'(e_err));
      rd = resp_rdata;
      er = resp_err;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         check("hold_valid", 32'(resp_valid), 32'd1);
         check("hold_rdata", resp_rdata, e_rd);
         check("hold_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("done_valid", 32'(resp_valid), 32'd0);
      check("done_ready", 32'(req_ready), 32'd1);
      check("n_read", 32'(mon_rd - r0), 32'(e_nr));
      check("n_write", 32'(mon_wr - w0), 32'(e_nw));
      if (e_nr != 0)
         check("rd_addr", mon_ra, addr & ~32'd3);
      if (e_nw != 0) begin
         check("wr_addr", mon_wa, addr & ~32'd3);
         check("wr_data", mon_wd, e_wd);
      end
      check("dmtype", 32'(DMType), 32'd2);
      if (e_err)
         m_errs++;
      else if (we)
         m_stores++;
      else
         m_loads++;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
      check({tag, "_rdata"}, resp_rdata, 32'd0);
      check({tag, "_err"}, 32'(resp_err), 32'd0);
      check({tag, "_memread"}, 32'(MemRead), 32'd0);
      check({tag, "_memwrite"}, 32'(MemWrite), 32'd0);
      check({tag, "_address"}, Address, 32'd0);
      check({tag, "_wdata"}, Write_data, 32'd0);
      check({tag, "_dmtype"}, 32'(DMType), 32'd2);
   endtask

   task automatic check_stats(input string tag);
`ifdef LSU_STATS_EN
      check({tag, "_loads"}, stat_loads, 32'(m_loads));
      check({tag, "_stores"}, stat_stores, 32'(m_stores));
      check({tag, "_errs"}, stat_errs, 32'(m_errs));
`else
      check({tag, "_idle"}, 32'(req_ready), 32'd1);
`endif
   endtask

   logic [31:0] rd;
   logic        er;
   logic [31:0] a;
   logic [2:0]  f3;

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      resp_ready = 1'b0;
      for (int i = 0; i < 64; i++)
         preload(i, $urandom);
      preload(MW - 1, $urandom);
      preload(4, 32'h8899_AABB);
      preload(8, 32'hDEAD_BEEF);
      @(negedge clk);
      check_reset("rst");
      rst = 1'b0;

      xact(0, 3'b000, 32'h13, 32'h0, 0, rd, er);
      check("plan_lb", rd, 32'hFFFF_FF88);
      xact(0, 3'b101, 32'h12, 32'h0, 0, rd, er);
      check("plan_lhu", rd, 32'h0000_8899);
      xact(0, 3'b001, 32'h11, 32'h0, 0, rd, er);
      check("plan_lh_err", 32'(er), 32'd1);
      xact(1, 3'b000, 32'h21, 32'h1234_56CC, 0, rd, er);
      check("plan_sb_wd", mon_wd, 32'hDEAD_CCEF);
      xact(0, 3'b010, 32'h20, 32'h0, 0, rd, er);
      check("plan_lw", rd, 32'hDEAD_CCEF);
      xact(1, 3'b010, 32'h40, 32'hCAFE_F00D, 5, rd, er);
      check("plan_sw_wd", mon_wd, 32'hCAFE_F00D);
      xact(0, 3'b010, 4 * MW, 32'h0, 0, rd, er);
      check("plan_oor", 32'(er), 32'd1);
      xact(0, 3'b010, 4 * (MW - 1), 32'h0, 1, rd, er);
      check("plan_last", 32'(er), 32'd0);
      check_stats("stats_plan");

      // reset while the read is on the bus
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h10;
      resp_ready = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      check("mid_memread", 32'(MemRead), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset("mid");
      m_loads  = 0;
      m_stores = 0;
      m_errs   = 0;
      check_stats("stats_rst");
      rst = 1'b0;

      for (int n = 0; n < 200; n++) begin
         case ($urandom_range(0, 9))
            0:       a = 4 * (MW - 1) + $urandom_range(0, 3);
            1:       a = 4 * MW + $urandom_range(0, 7);
            2:       a = 32'hFFFF_FFFC;
            default: a = $urandom_range(0, 255);
         endcase
         f3 = 3'($urandom);
         xact(1'($urandom), f3, a, $urandom, $urandom_range(0, 3), rd, er);
      end
      check_stats("stats_end");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
